// File: rtl/gate_delay_monitor_pkg.sv
// Shared types for the gate delay monitor.
//   kind_e  : classification of a stimulus change (RISE / FALL / OFF)
//   state_e : measurement FSM states (IDLE / WAIT)
package gate_delay_monitor_pkg;

  typedef enum logic [1:0] {
    KIND_RISE = 2'd0,
    KIND_FALL = 2'd1,
    KIND_OFF  = 2'd2
  } kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/gate_delay_monitor_if.sv
// Bundle between the test harness and the gate delay monitor.
//   in, ctrl          : stimulus applied to the bufif0-style driver
//   out_en, out_val   : observed driver output (out_en=0 means Z)
//   meas_*            : measurement report (valid pulse, kind, delay, error)
//   meas_cancel       : pending measurement pre-empted by a new event
//   timeout           : no output match within the timeout window
//   err_cnt           : saturating error count
// slave = monitor side, master = harness side.
interface gate_delay_monitor_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             ctrl;
  logic             out_en;
  logic             out_val;
  logic             meas_valid;
  logic [1:0]       meas_kind;
  logic [CNT_W-1:0] meas_dly;
  logic             meas_err;
  logic             meas_cancel;
  logic             timeout;
  logic [7:0]       err_cnt;

  modport slave (
    input  in, ctrl, out_en, out_val,
    output meas_valid, meas_kind, meas_dly, meas_err, meas_cancel, timeout, err_cnt
  );

  modport master (
    output in, ctrl, out_en, out_val,
    input  meas_valid, meas_kind, meas_dly, meas_err, meas_cancel, timeout, err_cnt
  );
endinterface

// File: rtl/gate_delay_monitor_edge_classifier.sv
// Tracks the target output implied by the driver stimulus and flags changes.
//   clk, rst     : clock and synchronous active-high reset
//   in_i, ctrl_i : driver stimulus (ctrl=1 means the driver floats)
//   event_o      : target differs from the previous cycle's target
//   kind_o       : RISE / FALL / OFF classification of the change
//   tgt_en_o     : target is driven
//   tgt_val_o    : target level (don't-care when tgt_en_o=0)
module gate_delay_edge_classifier
  import gate_delay_monitor_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_i,
  input  logic  ctrl_i,
  output logic  event_o,
  output kind_e kind_o,
  output logic  tgt_en_o,
  output logic  tgt_val_o
);

  logic prev_en_q;
  logic prev_val_q;
  logic primed_q;
  logic differ;

  assign tgt_en_o  = ~ctrl_i;
  assign tgt_val_o = in_i;

  // The level only matters when both the old and the new target are driven.
  assign differ  = (tgt_en_o != prev_en_q) ||
                   (tgt_en_o && prev_en_q && (tgt_val_o != prev_val_q));
  // The first cycle after reset only captures a reference target.
  assign event_o = primed_q && differ;

  always_comb begin
    kind_o = KIND_OFF;
    if (tgt_en_o) begin
      kind_o = tgt_val_o ? KIND_RISE : KIND_FALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_en_q  <= 1'b0;
      prev_val_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      prev_en_q  <= tgt_en_o;
      prev_val_q <= tgt_val_o;
      primed_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/gate_delay_monitor.sv
// Receiving-side delay checker for a bufif0-style driver.
// Measures the cycles from each stimulus change to the matching output change
// and compares them against the expected rise / fall / turn-off delays.
//   clk, rst : clock and synchronous active-high reset
//   mon      : stimulus/observation inputs and measurement report outputs
module gate_delay_monitor
  import gate_delay_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int RISE_EXP = 10,
  parameter int FALL_EXP = 12,
  parameter int OFF_EXP  = 11,
  parameter int TIMEOUT  = 255
) (
  input logic                  clk,
  input logic                  rst,
  gate_delay_monitor_if.slave  mon
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             ev;
  kind_e            ev_kind;
  logic             ev_tgt_en;
  logic             ev_tgt_val;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             tgt_en_q, tgt_en_d;
  logic             tgt_val_q, tgt_val_d;
  kind_e            kind_q, kind_d;

  logic             match_new, match_held, start;
  logic             rep_d;
  kind_e            rep_kind_d;
  logic [CNT_W-1:0] rep_dly_d, exp_dly;
  logic             rep_err_d, cancel_d, timeout_d;

  logic             valid_q, err_q, cancel_q, timeout_q;
  kind_e            rep_kind_q;
  logic [CNT_W-1:0] rep_dly_q;
  logic [7:0]       err_cnt_q;

  gate_delay_edge_classifier u_cls (
    .clk       (clk),
    .rst       (rst),
    .in_i      (mon.in),
    .ctrl_i    (mon.ctrl),
    .event_o   (ev),
    .kind_o    (ev_kind),
    .tgt_en_o  (ev_tgt_en),
    .tgt_val_o (ev_tgt_val)
  );

  // Observed output level is irrelevant when the target is Z.
  assign match_new  = (mon.out_en == ev_tgt_en) && (!ev_tgt_en || (mon.out_val == ev_tgt_val));
  assign match_held = (mon.out_en == tgt_en_q)  && (!tgt_en_q  || (mon.out_val == tgt_val_q));
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_en_d   = tgt_en_q;
    tgt_val_d  = tgt_val_q;
    kind_d     = kind_q;
    start      = 1'b0;
    rep_d      = 1'b0;
    rep_kind_d = kind_q;
    rep_dly_d  = cnt_q;
    cancel_d   = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start = ev;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (match_held) begin
          // A match on the same edge as a new event is still reported.
          rep_d      = 1'b1;
          rep_kind_d = kind_q;
          rep_dly_d  = cnt_inc;
          state_d    = ST_IDLE;
          start      = ev;
        end else if (ev) begin
          cancel_d = 1'b1;
          start    = 1'b1;
        end else if (cnt_inc == TIMEOUT_C) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      tgt_en_d  = ev_tgt_en;
      tgt_val_d = ev_tgt_val;
      kind_d    = ev_kind;
      cnt_d     = '0;
      if (match_new && !rep_d) begin
        rep_d      = 1'b1;
        rep_kind_d = ev_kind;
        rep_dly_d  = '0;
        state_d    = ST_IDLE;
      end else begin
        state_d = ST_WAIT;
      end
    end
  end

  always_comb begin
    case (rep_kind_d)
      KIND_RISE: exp_dly = CNT_W'(RISE_EXP);
      KIND_FALL: exp_dly = CNT_W'(FALL_EXP);
      default:   exp_dly = CNT_W'(OFF_EXP);
    endcase
    rep_err_d = (rep_dly_d != exp_dly);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_en_q   <= 1'b0;
      tgt_val_q  <= 1'b0;
      kind_q     <= KIND_RISE;
      valid_q    <= 1'b0;
      rep_kind_q <= KIND_RISE;
      rep_dly_q  <= '0;
      err_q      <= 1'b0;
      cancel_q   <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_en_q  <= tgt_en_d;
      tgt_val_q <= tgt_val_d;
      kind_q    <= kind_d;
      valid_q   <= rep_d;
      cancel_q  <= cancel_d;
      timeout_q <= timeout_d;
      if (rep_d) begin
        rep_kind_q <= rep_kind_d;
        rep_dly_q  <= rep_dly_d;
        err_q      <= rep_err_d;
      end
      if (((rep_d && rep_err_d) || timeout_d) && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign mon.meas_valid  = valid_q;
  assign mon.meas_kind   = rep_kind_q;
  assign mon.meas_dly    = rep_dly_q;
  assign mon.meas_err    = err_q;
  assign mon.meas_cancel = cancel_q;
  assign mon.timeout     = timeout_q;
  assign mon.err_cnt     = err_cnt_q;

endmodule
